// File: rtl/data_memory_responder.sv
// Data-memory responder: serves pipeline loads/stores from a byte-addressed,
// little-endian array after a fixed wait, stalling the pipeline via BUSY_WAIT.
module data_memory_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT
);

  localparam int unsigned IdxW = $clog2(DEPTH_BYTES);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      read_q;
  logic [2:0]      write_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic            req;
  logic            complete;
  logic            do_store;
  logic            do_load;
  logic [IdxW-1:0] st_base;
  logic [IdxW-1:0] ld_base;
  logic [7:0]      ld_b0, ld_b1, ld_b2, ld_b3;
  logic [31:0]     ld_data;

  assign req       = READ[3] | WRITE[2];
  assign complete  = (state_q == StWait) && (cnt_q == CntLast);
  // A combined load+store request performs only the store.
  assign do_store  = complete & write_q[2];
  assign do_load   = complete & read_q[3] & ~write_q[2];
  assign BUSY_WAIT = ((state_q == StIdle) & req) | (state_q == StWait);

  // Align the latched address to the access size; index wraps in the array.
  always_comb begin
    st_base = addr_q;
    ld_base = addr_q;
    case (write_q[1:0])
      2'b01:   st_base[0]   = 1'b0;
      2'b10:   st_base[1:0] = 2'b00;
      default: ;
    endcase
    case (read_q[1:0])
      2'b01:   ld_base[0]   = 1'b0;
      2'b10:   ld_base[1:0] = 2'b00;
      default: ;
    endcase
  end

  // Gather load bytes and apply width/sign extension.
  always_comb begin
    ld_b0 = mem[ld_base];
    ld_b1 = mem[ld_base + IdxW'(1)];
    ld_b2 = mem[ld_base + IdxW'(2)];
    ld_b3 = mem[ld_base + IdxW'(3)];
    case (read_q[2:0])
      3'b000:  ld_data = {{24{ld_b0[7]}}, ld_b0};
      3'b001:  ld_data = {{16{ld_b1[7]}}, ld_b1, ld_b0};
      3'b010:  ld_data = {ld_b3, ld_b2, ld_b1, ld_b0};
      3'b100:  ld_data = {24'h0, ld_b0};
      3'b101:  ld_data = {16'h0, ld_b1, ld_b0};
      default: ld_data = 32'h0;
    endcase
  end

  // Array write port; contents survive reset, and a reset edge aborts a pending store.
  always_ff @(posedge CLK) begin
    if (RESET && do_store) begin
      case (write_q[1:0])
        2'b00: mem[st_base] <= wdata_q[7:0];
        2'b01: begin
          mem[st_base]            <= wdata_q[7:0];
          mem[st_base + IdxW'(1)] <= wdata_q[15:8];
        end
        2'b10: begin
          mem[st_base]            <= wdata_q[7:0];
          mem[st_base + IdxW'(1)] <= wdata_q[15:8];
          mem[st_base + IdxW'(2)] <= wdata_q[23:16];
          mem[st_base + IdxW'(3)] <= wdata_q[31:24];
        end
        default: ;
      endcase
    end
  end

  // Handshake FSM: latch request, count wait cycles, complete, then one DONE cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      READ_DATA <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= ADDRESS[IdxW-1:0];
            wdata_q <= WRITE_DATA;
            read_q  <= READ;
            write_q <= WRITE;
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            if (do_load) READ_DATA <= ld_data;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        // Inputs still held here belong to the finished access.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases plus random
// accesses compared against a byte-array reference model.
module tb_data_memory_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  ref_mem [Depth];
  logic [31:0] ref_rd;

  data_memory_responder #(
    .DEPTH_BYTES(Depth),
    .LATENCY    (Lat)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .READ_DATA (READ_DATA),
    .BUSY_WAIT (BUSY_WAIT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference load: size from funct3, aligned base, wrap modulo Depth.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    longint unsigned base;
    logic [31:0] v;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 32'h0;
    sz   = 1 << f3[1:0];
    base = longint'(a) - (longint'(a) % sz);
    v    = 32'h0;
    for (int k = 0; k < int'(sz); k++)
      v = v | (32'(ref_mem[(base + longint'(k)) % Depth]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
    int unsigned sz;
    longint unsigned base;
    if (code == 2'b11) return;
    sz   = 1 << code;
    base = longint'(a) - (longint'(a) % sz);
    for (int k = 0; k < int'(sz); k++)
      ref_mem[(base + longint'(k)) % Depth] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic idle_inputs();
    READ       = 4'h0;
    WRITE      = 3'h0;
    ADDRESS    = 32'h0;
    WRITE_DATA = 32'h0;
  endtask

  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    int unsigned n;
    READ       = rd;
    WRITE      = wr;
    ADDRESS    = addr;
    WRITE_DATA = wd;
    n = 0;
    @(negedge CLK);
    while (BUSY_WAIT === 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check_eq("busy_len", n, Lat + 1);
    if (wr[2]) ref_store(wr[1:0], addr, wd);
    else if (rd[3]) ref_rd = ref_load(rd[2:0], addr);
    check_eq("read_data", READ_DATA, ref_rd);
    if (!hold) idle_inputs();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    ref_rd = 32'h0;
    RESET  = 1'b0;
    idle_inputs();

    // Reset then idle.
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("rst_busy", BUSY_WAIT, 1'b0);
    check_eq("rst_rdata", READ_DATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("idle_busy", BUSY_WAIT, 1'b0);
    end
    check_eq("idle_rdata", READ_DATA, 32'h0);
    @(posedge CLK); #1;

    // Fill the whole array so every later load is defined.
    for (int i = 0; i < int'(Depth / 4); i++) access(4'h0, 3'b110, 32'(i * 4), $urandom, 1'b0);

    // Word store/load and sub-word extension.
    access(4'h0, 3'b110, 32'h10, 32'hDEADBEEF, 1'b0);
    access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("lw", READ_DATA, 32'hDEADBEEF);
    access(4'b1000, 3'h0, 32'h13, 32'h0, 1'b0);
    check_eq("lb", READ_DATA, 32'hFFFFFFDE);
    access(4'b1100, 3'h0, 32'h13, 32'h0, 1'b0);
    check_eq("lbu", READ_DATA, 32'h000000DE);
    access(4'b1001, 3'h0, 32'h12, 32'h0, 1'b0);
    check_eq("lh", READ_DATA, 32'hFFFFDEAD);
    access(4'b1101, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("lhu", READ_DATA, 32'h0000BEEF);
    access(4'h0, 3'b100, 32'h11, 32'h55, 1'b0);
    check_eq("store_keeps_rdata", READ_DATA, 32'h0000BEEF);
    access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("sb_merge", READ_DATA, 32'hDEAD55EF);

    // Alignment and wrap.
    access(4'b1010, 3'h0, 32'h13, 32'h0, 1'b0);
    check_eq("lw_align", READ_DATA, 32'hDEAD55EF);
    access(4'h0, 3'b110, Depth + 32'h20, 32'h11223344, 1'b0);
    access(4'b1010, 3'h0, 32'h20, 32'h0, 1'b0);
    check_eq("wrap", READ_DATA, 32'h11223344);

    // Reset during the first wait cycle of a store.
    READ = 4'h0; WRITE = 3'b110; ADDRESS = 32'h10; WRITE_DATA = 32'hAAAAAAAA;
    @(negedge CLK);
    check_eq("abort_req_busy", BUSY_WAIT, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle_inputs();
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("abort_busy", BUSY_WAIT, 1'b0);
    check_eq("abort_rdata", READ_DATA, 32'h0);
    ref_rd = 32'h0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("abort_mem", READ_DATA, 32'hDEAD55EF);

    // Held load: one access per DONE, next one restarts from IDLE.
    access(4'b1010, 3'h0, 32'h20, 32'h0, 1'b1);
    access(4'b1010, 3'h0, 32'h20, 32'h0, 1'b1);
    access(4'b1010, 3'h0, 32'h20, 32'h0, 1'b0);

    // Illegal codes.
    access(4'b1011, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("ld_illegal", READ_DATA, 32'h0);
    access(4'h0, 3'b111, 32'h10, 32'hFFFFFFFF, 1'b0);
    access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0);
    check_eq("st_illegal", READ_DATA, 32'hDEAD55EF);

    // Combined request performs only the store.
    access(4'b1010, 3'b110, 32'h30, 32'hCAFEF00D, 1'b0);
    check_eq("combo_rdata", READ_DATA, 32'hDEAD55EF);

    // Random accesses.
    for (int i = 0; i < 300; i++) begin
      rd = {1'b0, 3'($urandom)};
      wr = {1'b0, 2'($urandom)};
      case ($urandom_range(0, 9))
        0:             begin rd[3] = 1'b1; wr[2] = 1'b1; end
        1, 2, 3, 4:    rd[3] = 1'b1;
        default:       wr[2] = 1'b1;
      endcase
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      access(rd, wr, a, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
